tff_mem_ctrl: RTL

Synchronous controller for a bank of CELLS temporal flip-flop cells. Each cell stores a duration as ring-oscillator state: a WE pulse of length T adds T, and an RE pulse runs until the cell's out rises after about T.
The block arbitrates between one write requester and one read requester, generates the per-cell WE/RE/rstb strobes, and measures read-out duration in clock cycles. A destructive read clears the cell afterwards.
It sits between the race-logic datapath and the tff bank.

---
 rtl/tff_mem_ctrl.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/tff_mem_ctrl.sv
// Write/read/clear sequencer for a bank of temporal flip-flop cells; reads are measured in clk cycles.
// Optional TFF_MEM_CTRL_CLR_ALL_EN adds clr_all_i, which clears every cell from IDLE.
module tff_mem_ctrl #(
  parameter int CELLS    = 4,
  parameter int AW       = 2,
  parameter int TW       = 8,
  parameter int SYNC_LAT = 2
) (
  input  logic             clk,
  input  logic             rstb,
`ifdef TFF_MEM_CTRL_CLR_ALL_EN
  input  logic             clr_all_i,
`endif
  input  logic             wr_req_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [TW-1:0]    wr_time_i,
  output logic             wr_ack_o,
  input  logic             rd_req_i,
  input  logic [AW-1:0]    rd_addr_i,
  output logic             rd_ack_o,
  output logic             rd_valid_o,
  output logic [TW-1:0]    rd_time_o,
  output logic             rd_ovf_o,
  output logic             busy_o,
  output logic [CELLS-1:0] occ_o,
  output logic [CELLS-1:0] tff_we_o,
  output logic [CELLS-1:0] tff_re_o,
  output logic [CELLS-1:0] tff_rstb_o,
  input  logic [CELLS-1:0] tff_out_i
);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_CLEAR} state_t;

  localparam logic [TW-1:0] ONE   = TW'(1);
  localparam logic [TW-1:0] LAT_W = TW'(SYNC_LAT);

  state_t           state_q, state_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [TW-1:0]    cnt_q, cnt_d;
  logic             empty_q, empty_d;
  logic             all_q, all_d;
  logic             last_rd_q, last_rd_d;
  logic             wr_ack_q, wr_ack_d, rd_ack_q, rd_ack_d, rd_valid_q, rd_valid_d;
  logic [TW-1:0]    rd_time_q, rd_time_d;
  logic             rd_ovf_q, rd_ovf_d, busy_q, busy_d;
  logic [CELLS-1:0] occ_q, occ_d, we_q, we_d, re_q, re_d, rstb_q, rstb_d;
  logic [CELLS-1:0] sync_q [SYNC_LAT];
  logic [CELLS-1:0] sync_nxt;
  logic             clr_req, grant_wr, rise;

`ifdef TFF_MEM_CTRL_CLR_ALL_EN
  assign clr_req = clr_all_i;
`else
  assign clr_req = 1'b0;
`endif

  // Edge is taken on the value the last sync stage is about to load, so it is registered at that edge.
  if (SYNC_LAT > 1) begin : g_sync
    assign sync_nxt = sync_q[SYNC_LAT-2];
  end else begin : g_nosync
    assign sync_nxt = tff_out_i;
  end

  assign rise     = sync_nxt[addr_q] & ~sync_q[SYNC_LAT-1][addr_q];
  assign grant_wr = wr_req_i & (~rd_req_i | last_rd_q);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    empty_d    = empty_q;
    all_d      = all_q;
    last_rd_d  = last_rd_q;
    wr_ack_d   = 1'b0;
    rd_ack_d   = 1'b0;
    rd_valid_d = 1'b0;
    rd_time_d  = rd_time_q;
    rd_ovf_d   = rd_ovf_q;
    occ_d      = occ_q;
    we_d       = '0;
    re_d       = '0;
    rstb_d     = '1;
    case (state_q)
      S_IDLE: begin
        if (clr_req) begin
          all_d   = 1'b1;
          cnt_d   = '0;
          state_d = S_CLEAR;
        end else if (grant_wr) begin
          wr_ack_d  = 1'b1;
          addr_d    = wr_addr_i;
          cnt_d     = wr_time_i;
          last_rd_d = 1'b0;
          state_d   = S_WRITE;
        end else if (rd_req_i) begin
          rd_ack_d  = 1'b1;
          addr_d    = rd_addr_i;
          cnt_d     = '0;
          empty_d   = ~occ_q[rd_addr_i];
          all_d     = 1'b0;
          last_rd_d = 1'b1;
          state_d   = S_READ;
        end
      end
      S_WRITE: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          we_d[addr_q] = 1'b1;
          cnt_d        = cnt_q - ONE;
          if (cnt_q == ONE) begin
            occ_d[addr_q] = 1'b1;
            state_d       = S_IDLE;
          end
        end
      end
      S_READ: begin
        if (empty_q) begin
          rd_valid_d = 1'b1;
          rd_time_d  = '0;
          rd_ovf_d   = 1'b0;
          state_d    = S_IDLE;
        end else if (cnt_q == '0) begin
          re_d[addr_q] = 1'b1;
          cnt_d        = ONE;
        end else if (rise) begin
          rd_time_d = (cnt_q > LAT_W) ? cnt_q - LAT_W : '0;
          rd_ovf_d  = 1'b0;
          cnt_d     = '0;
          state_d   = S_CLEAR;
        end else if (cnt_q == '1) begin
          rd_time_d = '1;
          rd_ovf_d  = 1'b1;
          cnt_d     = '0;
          state_d   = S_CLEAR;
        end else begin
          re_d[addr_q] = 1'b1;
          cnt_d        = cnt_q + ONE;
        end
      end
      S_CLEAR: begin
        if (all_q) rstb_d = '0;
        else       rstb_d[addr_q] = 1'b0;
        if (cnt_q == '0) begin
          rd_valid_d = ~all_q;
          cnt_d      = ONE;
        end else begin
          if (all_q) occ_d = '0;
          else       occ_d[addr_q] = 1'b0;
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      cnt_q      <= '0;
      empty_q    <= 1'b0;
      all_q      <= 1'b0;
      last_rd_q  <= 1'b1;
      wr_ack_q   <= 1'b0;
      rd_ack_q   <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_time_q  <= '0;
      rd_ovf_q   <= 1'b0;
      busy_q     <= 1'b0;
      occ_q      <= '0;
      we_q       <= '0;
      re_q       <= '0;
      rstb_q     <= '0;
      for (int i = 0; i < SYNC_LAT; i++) sync_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      empty_q    <= empty_d;
      all_q      <= all_d;
      last_rd_q  <= last_rd_d;
      wr_ack_q   <= wr_ack_d;
      rd_ack_q   <= rd_ack_d;
      rd_valid_q <= rd_valid_d;
      rd_time_q  <= rd_time_d;
      rd_ovf_q   <= rd_ovf_d;
      busy_q     <= busy_d;
      occ_q      <= occ_d;
      we_q       <= we_d;
      re_q       <= re_d;
      rstb_q     <= rstb_d;
      sync_q[0]  <= tff_out_i;
      for (int i = 1; i < SYNC_LAT; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign wr_ack_o   = wr_ack_q;
  assign rd_ack_o   = rd_ack_q;
  assign rd_valid_o = rd_valid_q;
  assign rd_time_o  = rd_time_q;
  assign rd_ovf_o   = rd_ovf_q;
  assign busy_o     = busy_q;
  assign occ_o      = occ_q;
  assign tff_we_o   = we_q;
  assign tff_re_o   = re_q;
  assign tff_rstb_o = rstb_q;

endmodule
